// File: rtl/drum_line_port.sv
// drum_line_port: word-addressed read / write-exchange port for one drum line.
// Recirculates the attached track by default. A request waits for its word to
// come round, then captures it serially and optionally substitutes new bits.
// Ports: clk, rst (async, active high), dout_trk/din_trk (track loop),
// req_valid/req_ready/req_write/req_addr/req_wdata (request),
// rsp_valid/rsp_err/rsp_rdata (one-cycle completion), bit_t/word_t (position).
// Define DRUM_PORT_ABORT_EN to add req_abort (cancel a request still in ARM).
module drum_line_port #(
  parameter int WORD_BITS = 29,
  parameter int WORDS     = 108,
  parameter int AW        = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dout_trk,
  output logic                 din_trk,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [AW-1:0]        req_addr,
  input  logic [WORD_BITS-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic                 rsp_err,
  output logic [WORD_BITS-1:0] rsp_rdata,
  output logic [4:0]           bit_t,
  output logic [AW-1:0]        word_t
`ifdef DRUM_PORT_ABORT_EN
  ,
  input  logic                 req_abort
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARM  = 2'd1;
  localparam logic [1:0] XFER = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [4:0]    BLAST  = 5'(WORD_BITS - 1);
  localparam logic [AW-1:0] WLAST  = AW'(WORDS - 1);
  localparam logic [AW:0]   NWORDS = (AW + 1)'(WORDS);

  logic [1:0]           state;
  logic                 wr_q;
  logic                 err_q;
  logic [AW-1:0]        addr_q;
  logic [AW-1:0]        prev;
  logic [WORD_BITS-1:0] wdata_q;
  logic [WORD_BITS-1:0] rdata_sh;
  logic                 wrap;
  logic                 oob;
  logic                 hit;
  logic                 abort;

  assign wrap = (bit_t == BLAST);
  assign oob  = ({1'b0, req_addr} >= NWORDS);

  // The target word starts right after the last bit of its predecessor.
  assign prev = (addr_q == '0) ? WLAST : addr_q - AW'(1);
  assign hit  = wrap && (word_t == prev);

`ifdef DRUM_PORT_ABORT_EN
  assign abort = req_abort;
`else
  assign abort = 1'b0;
`endif

  // Held low during the response pulse so a new request lands after it.
  assign req_ready = (state == IDLE) && !rsp_valid;

  assign din_trk = (state == XFER && wr_q) ? wdata_q[bit_t] : dout_trk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_t     <= '0;
      word_t    <= '0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_sh  <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      bit_t <= wrap ? '0 : bit_t + 5'd1;
      if (wrap)
        word_t <= (word_t == WLAST) ? '0 : word_t + AW'(1);

      rsp_valid <= (state == DONE);
      rsp_err   <= (state == DONE) && err_q;

      unique case (1'b1)
        state == IDLE: begin
          if (req_valid && req_ready) begin
            wr_q    <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            err_q   <= oob;
            state   <= oob ? DONE : ARM;
          end
        end
        state == ARM: begin
          if (abort) begin
            err_q <= 1'b1;
            state <= DONE;
          end else if (hit) begin
            state <= XFER;
          end
        end
        state == XFER: begin
          rdata_sh[bit_t] <= dout_trk;
          if (wrap)
            state <= DONE;
        end
        state == DONE: begin
          rsp_rdata <= err_q ? '0 : rdata_sh;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_drum_line_port.sv
// tb_drum_line_port: drum_line_port with a modelled 3132-bit track.
// Word w of the track starts as w*3; a word-level model tracks expectations.
module tb_drum_line_port;

  localparam int WB  = 29;
  localparam int NW  = 108;
  localparam int N   = WB * NW;
  localparam int BUD = 2 * N + 100;
  localparam int BIG = 1 << 30;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dout_trk;
  logic        din_trk;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [6:0]  req_addr = '0;
  logic [28:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_err;
  logic [28:0] rsp_rdata;
  logic [4:0]  bit_t;
  logic [6:0]  word_t;
`ifdef DRUM_PORT_ABORT_EN
  logic        req_abort = 1'b0;
`endif

  drum_line_port dut (
    .clk       (clk),
    .rst       (rst),
    .dout_trk  (dout_trk),
    .din_trk   (din_trk),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata),
    .bit_t     (bit_t),
`ifdef DRUM_PORT_ABORT_EN
    .word_t    (word_t),
    .req_abort (req_abort)
`else
    .word_t    (word_t)
`endif
  );

  always #5 clk = ~clk;

  // Track: a circulating bit line whose index mark realigns on reset.
  logic trk [N];
  int   tpos;
  assign dout_trk = trk[tpos];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tpos <= 0;
    end else begin
      trk[tpos] <= din_trk;
      tpos <= (tpos == N - 1) ? 0 : tpos + 1;
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  // Word-level reference model.
  logic [28:0] ref_mem [NW];
  logic        pending = 1'b0;
  int          cyc = 0;
  logic        p_wr;
  int          p_addr;
  logic [28:0] p_wdata;
  logic [28:0] p_old;
  logic        p_err;
  int          p_acc;
  int          p_t;
  int          p_xs = BIG;
  int          p_exp;
  logic [28:0] exp_rdata = '0;

  always @(negedge clk) begin : cmp
    logic wp;
    logic rv;
    logic ed;
    int   pp;
    int   tg;
    int   c1;
    if (rst) begin
      if (pending && p_wr && !p_err)
        for (int b = 0; b < WB; b++)
          if (p_xs + b < cyc)
            ref_mem[p_addr][b] = p_wdata[b];
      pending   = 1'b0;
      p_xs      = BIG;
      cyc       = 0;
      exp_rdata = '0;
    end else begin
      wp = pending;
      pp = cyc % N;
      chk("bit_t", 32'(bit_t), 32'(pp % WB));
      chk("word_t", 32'(word_t), 32'(pp / WB));
      rv = pending && (cyc == p_exp);
      chk("rsp_valid", 32'(rsp_valid), 32'(rv));
      chk("req_ready", 32'(req_ready), 32'(!pending));
      ed = dout_trk;
      if (pending && p_wr && cyc >= p_xs && cyc < p_xs + WB)
        ed = p_wdata[cyc - p_xs];
      chk("din_trk", 32'(din_trk), 32'(ed));
      if (rv) begin
        if (p_err) begin
          exp_rdata = '0;
        end else begin
          exp_rdata = p_old;
          if (p_wr)
            ref_mem[p_addr] = p_wdata;
        end
      end
      chk("rsp_err", 32'(rsp_err), 32'(rv && p_err));
      chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
`ifdef DRUM_PORT_ABORT_EN
      if (pending && !p_err && req_abort && cyc > p_acc && cyc <= p_t) begin
        p_err = 1'b1;
        p_exp = cyc + 2;
        p_xs  = BIG;
      end
`endif
      if (!wp && req_valid) begin
        pending = 1'b1;
        p_acc   = cyc;
        p_wr    = req_write;
        p_addr  = int'(req_addr);
        p_wdata = req_wdata;
        if (p_addr >= NW) begin
          p_err = 1'b1;
          p_exp = cyc + 2;
          p_xs  = BIG;
          p_t   = cyc;
        end else begin
          p_err = 1'b0;
          p_old = ref_mem[p_addr];
          tg    = (p_addr * WB + N - 1) % N;
          c1    = cyc + 1;
          p_t   = c1 + ((tg - (c1 % N) + N) % N);
          p_xs  = p_t + 1;
          p_exp = p_t + 31;
        end
      end else if (rv) begin
        pending = 1'b0;
        p_xs    = BIG;
      end
      cyc++;
    end
  end

  task automatic issue(input logic wr, input logic [6:0] a,
                       input logic [28:0] wd, input logic hold);
    logic g;
    int   n;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = wd;
    n = 0;
    g = 1'b0;
    while (!g && n < BUD) begin
      @(negedge clk);
      g = req_ready;
      @(posedge clk);
      n++;
    end
    #1;
    if (!hold)
      req_valid = 1'b0;
    if (!g)
      chk("accept_timeout", 32'(g), 32'd1);
  endtask

  task automatic wait_rsp(output logic [28:0] rd, output logic er,
                          output int lat);
    lat = 1;
    @(negedge clk);
    while (!rsp_valid && lat < BUD) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("rsp_seen", 32'(rsp_valid), 32'd1);
    rd = rsp_rdata;
    er = rsp_err;
    @(posedge clk);
    #1;
  endtask

  task automatic xact(input logic wr, input logic [6:0] a,
                      input logic [28:0] wd, output logic [28:0] rd,
                      output logic er, output int lat);
    issue(wr, a, wd, 1'b0);
    wait_rsp(rd, er, lat);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    logic [28:0] rd;
    logic [28:0] rd_a;
    logic        er;
    logic        got_a;
    int          lat;
    int          n;
    int          bad;
    logic [28:0] w;

    for (int i = 0; i < NW; i++) begin
      ref_mem[i] = 29'(i * 3);
      for (int b = 0; b < WB; b++)
        trk[i * WB + b] <= ref_mem[i][b];
    end
    tpos <= 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_bit_t", 32'(bit_t), 32'd0);
    chk("rst_word_t", 32'(word_t), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_din", 32'(din_trk), 32'(dout_trk));
    rst = 1'b0;

    xact(1'b0, 7'd0, '0, rd, er, lat);
    chk("t1_rdata", 32'(rd), 32'd0);
    chk("t1_err", 32'(er), 32'd0);
    chk("t1_lat", 32'(lat >= 31 && lat <= WB * NW + 30), 32'd1);

    xact(1'b1, 7'd5, 29'h1ABCDEF0, rd, er, lat);
    chk("t2_old", 32'(rd), 32'd15);
    xact(1'b0, 7'd5, '0, rd, er, lat);
    chk("t2_rd5", 32'(rd), 32'h1ABCDEF0);
    xact(1'b0, 7'd4, '0, rd, er, lat);
    chk("t2_rd4", 32'(rd), 32'd12);
    xact(1'b0, 7'd6, '0, rd, er, lat);
    chk("t2_rd6", 32'(rd), 32'd18);

    xact(1'b1, 7'd107, 29'h1FFFFFFF, rd, er, lat);
    chk("t3_old", 32'(rd), 32'd321);
    xact(1'b0, 7'd107, '0, rd, er, lat);
    chk("t3_rd107", 32'(rd), 32'h1FFFFFFF);
    xact(1'b0, 7'd0, '0, rd, er, lat);
    chk("t3_rd0", 32'(rd), 32'd0);

    xact(1'b1, 7'd108, 29'h0123456, rd, er, lat);
    chk("t4_lat", 32'(lat), 32'd2);
    chk("t4_err", 32'(er), 32'd1);
    chk("t4_rdata", 32'(rd), 32'd0);

    issue(1'b0, 7'd50, '0, 1'b1);
    req_addr = 7'd51;
    bad = 0;
    got_a = 1'b0;
    rd_a = '0;
    n = 0;
    while (n < BUD) begin
      @(negedge clk);
      if (got_a && req_ready)
        break;
      if (req_ready)
        bad++;
      if (rsp_valid) begin
        got_a = 1'b1;
        rd_a = rsp_rdata;
      end
      n++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("t5_first_done", 32'(got_a), 32'd1);
    chk("t5_ready_low", 32'(bad), 32'd0);
    chk("t5_rd50", 32'(rd_a), 32'd150);
    wait_rsp(rd, er, lat);
    chk("t5_rd51", 32'(rd), 32'd153);

    issue(1'b1, 7'd9, 29'h1FFFFFFF, 1'b0);
    n = 0;
    while (cyc != p_xs + 10 && n < BUD) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t6_reach_bit10", 32'(bit_t), 32'd10);
    #2 rst = 1'b1;
    #1;
    chk("t6_bit_t", 32'(bit_t), 32'd0);
    chk("t6_word_t", 32'(word_t), 32'd0);
    chk("t6_no_rsp", 32'(rsp_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    xact(1'b0, 7'd9, '0, rd, er, lat);
    chk("t6_partial", 32'(rd), 32'h3FF);
    xact(1'b0, 7'd10, '0, rd, er, lat);
    chk("t6_rd10", 32'(rd), 32'd30);

`ifdef DRUM_PORT_ABORT_EN
    issue(1'b1, 7'd20, 29'h0AAAAAAA, 1'b0);
    req_abort = 1'b1;
    @(posedge clk);
    #1 req_abort = 1'b0;
    wait_rsp(rd, er, lat);
    chk("ab_err", 32'(er), 32'd1);
    chk("ab_rdata", 32'(rd), 32'd0);
    xact(1'b0, 7'd20, '0, rd, er, lat);
    chk("ab_rd20", 32'(rd), 32'd60);
`endif

    for (int i = 0; i < 12000; i++) begin
      @(posedge clk);
      #1;
      req_valid = 1'($urandom_range(0, 1));
      req_write = 1'($urandom_range(0, 1));
      req_addr  = 7'($urandom_range(0, 127));
      req_wdata = 29'($urandom());
`ifdef DRUM_PORT_ABORT_EN
      req_abort = ($urandom_range(0, 63) == 0);
`endif
    end
    req_valid = 1'b0;
`ifdef DRUM_PORT_ABORT_EN
    req_abort = 1'b0;
`endif
    n = 0;
    while (pending && n < BUD) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", 32'(pending), 32'd0);

    for (int i = 0; i < NW; i++) begin
      for (int b = 0; b < WB; b++)
        w[b] = trk[i * WB + b];
      chk("track_word", 32'(w), 32'(ref_mem[i]));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
